rs_alu_station: RTL

- Reservation station feeding the ALU; the consumer end of the common data bus.
- Accepts decoded instructions whose operands are either values or pending producer tags.
- Snoops both CDB broadcast channels (ALU and load/store) to capture pending operands.
- Dispatches the lowest-index entry with both operands ready to the ALU, one per cycle.

---
 rtl/rs_alu_station.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/rs_alu_station.sv
`default_nettype none
// ============================================================================
// Module   : rs_alu_station
// Purpose  : Reservation station in front of the ALU. Holds decoded
//            instructions whose operands are either values or pending
//            producer tags. It snoops both common-data-bus channels (ALU and
//            load/store) to wake pending operands, and dispatches the
//            lowest-index fully-ready entry to the ALU, at most one per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_in, rst_in          clock (rising edge), async active-high reset
//   flush_in                synchronous clear of every entry (mispredict)
//   issue_*                 new instruction: opcode, operand values/tags,
//                           pending flags, destination tag
//   full                    every entry busy; issue is ignored
//   alu_tag/result/done     CDB ALU broadcast channel
//   ls_tag/result/done      CDB load/store broadcast channel
//   alu_ready_in            ALU accepts an operation this cycle
//   out_valid               one-cycle dispatch pulse
//   out_op/out_a/out_b/out_dest  dispatched opcode, operands j/k, dest tag
// ============================================================================
module rs_alu_station #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 32,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  // issue port
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_j_pend,
  input  logic              issue_k_pend,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [TAG_W-1:0]  issue_dest,
  output logic              full,
  // CDB ALU channel
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_done,
  // CDB load/store channel
  input  logic [TAG_W-1:0]  ls_tag,
  input  logic [DATA_W-1:0] ls_result,
  input  logic              ls_done,
  // dispatch port
  input  logic              alu_ready_in,
  output logic              out_valid,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [TAG_W-1:0]  out_dest
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Per-entry state exported from the entry generate blocks
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  j_pend;
  logic [DEPTH-1:0]  k_pend;
  logic [OP_W-1:0]   e_op   [DEPTH];
  logic [DATA_W-1:0] e_vj   [DEPTH];
  logic [DATA_W-1:0] e_vk   [DEPTH];
  logic [TAG_W-1:0]  e_dest [DEPTH];

  // --------------------------------------------------------------------------
  // Issue-side operand resolution with same-cycle CDB bypass.
  // A pending operand whose producer is broadcasting right now is stored as
  // already ready; otherwise it would miss the broadcast forever.
  // ALU channel takes priority when both channels carry the same tag.
  // --------------------------------------------------------------------------
  logic              iss_j_alu, iss_j_ls, iss_k_alu, iss_k_ls;
  logic              iss_j_pend, iss_k_pend;
  logic [DATA_W-1:0] iss_vj, iss_vk;

  assign iss_j_alu  = issue_j_pend && alu_done && (alu_tag == issue_qj);
  assign iss_j_ls   = issue_j_pend && ls_done  && (ls_tag  == issue_qj);
  assign iss_k_alu  = issue_k_pend && alu_done && (alu_tag == issue_qk);
  assign iss_k_ls   = issue_k_pend && ls_done  && (ls_tag  == issue_qk);

  assign iss_vj     = iss_j_alu ? alu_result : (iss_j_ls ? ls_result : issue_vj);
  assign iss_vk     = iss_k_alu ? alu_result : (iss_k_ls ? ls_result : issue_vk);
  assign iss_j_pend = issue_j_pend && !iss_j_alu && !iss_j_ls;
  assign iss_k_pend = issue_k_pend && !iss_k_alu && !iss_k_ls;

  // --------------------------------------------------------------------------
  // Allocation: lowest-index free entry, from registered busy flags only, so
  // an entry being dispatched this cycle is never reused in the same cycle.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] free_idx;
  logic             issue_accept;

  assign full         = &busy;
  assign issue_accept = issue_valid && !full && !flush_in;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Dispatch select: lowest-index busy entry with both operands ready in the
  // registered state. Operands woken this cycle become eligible next cycle.
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] disp_idx;
  logic             disp_fire;

  assign ready_vec = busy & ~j_pend & ~k_pend;
  assign disp_fire = alu_ready_in && (|ready_vec) && !flush_in;

  always_comb begin
    disp_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        disp_idx = IDX_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Entries
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic              busy_q;
      logic              j_pend_q, k_pend_q;
      logic [OP_W-1:0]   op_q;
      logic [DATA_W-1:0] vj_q, vk_q;
      logic [TAG_W-1:0]  qj_q, qk_q, dest_q;

      logic issue_sel, disp_sel;
      logic j_wake_alu, j_wake_ls, k_wake_alu, k_wake_ls;

      assign issue_sel = issue_accept && (free_idx == IDX_W'(gi));
      assign disp_sel  = disp_fire    && (disp_idx == IDX_W'(gi));

      // Snoop comparators; a channel with done low never matches
      assign j_wake_alu = busy_q && j_pend_q && alu_done && (alu_tag == qj_q);
      assign j_wake_ls  = busy_q && j_pend_q && ls_done  && (ls_tag  == qj_q);
      assign k_wake_alu = busy_q && k_pend_q && alu_done && (alu_tag == qk_q);
      assign k_wake_ls  = busy_q && k_pend_q && ls_done  && (ls_tag  == qk_q);

      // issue_sel only hits free entries; dispatch and snoop only affect busy
      // ones, so the branches below never compete for the same entry.
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          busy_q   <= 1'b0;
          j_pend_q <= 1'b0;
          k_pend_q <= 1'b0;
          op_q     <= '0;
          vj_q     <= '0;
          vk_q     <= '0;
          qj_q     <= '0;
          qk_q     <= '0;
          dest_q   <= '0;
        end else if (flush_in) begin
          busy_q <= 1'b0;
        end else if (issue_sel) begin
          busy_q   <= 1'b1;
          op_q     <= issue_op;
          vj_q     <= iss_vj;
          vk_q     <= iss_vk;
          j_pend_q <= iss_j_pend;
          k_pend_q <= iss_k_pend;
          qj_q     <= issue_qj;
          qk_q     <= issue_qk;
          dest_q   <= issue_dest;
        end else begin
          if (disp_sel) begin
            busy_q <= 1'b0;
          end
          if (j_wake_alu) begin
            vj_q     <= alu_result;
            j_pend_q <= 1'b0;
          end else if (j_wake_ls) begin
            vj_q     <= ls_result;
            j_pend_q <= 1'b0;
          end
          if (k_wake_alu) begin
            vk_q     <= alu_result;
            k_pend_q <= 1'b0;
          end else if (k_wake_ls) begin
            vk_q     <= ls_result;
            k_pend_q <= 1'b0;
          end
        end
      end

      assign busy[gi]   = busy_q;
      assign j_pend[gi] = j_pend_q;
      assign k_pend[gi] = k_pend_q;
      assign e_op[gi]   = op_q;
      assign e_vj[gi]   = vj_q;
      assign e_vk[gi]   = vk_q;
      assign e_dest[gi] = dest_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Dispatch output registers; payload holds its last value when idle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_dest  <= '0;
    end else if (disp_fire) begin
      out_valid <= 1'b1;
      out_op    <= e_op[disp_idx];
      out_a     <= e_vj[disp_idx];
      out_b     <= e_vk[disp_idx];
      out_dest  <= e_dest[disp_idx];
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
